uart_batch_receiver: RTL and testbench

//  Receive-side counterpart of the batched UART transmit path. Samples serial rx with the shared 16x baud tick.

---
 rtl/uart_batch_receiver_pkg.sv | 15 +
 rtl/uart_batch_receiver_rx_sync.sv | 22 ++
 rtl/uart_batch_receiver.sv | 186 ++++++++++++++++++
 tb/tb_uart_batch_receiver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_batch_receiver_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame parameters.
package uart_batch_receiver_pkg;

  localparam int DEFAULT_DBITS   = 8;
  localparam int DEFAULT_SB_TICK = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_batch_receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle-high level.
module uart_batch_receiver_rx_sync (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_reg;

  // Shift the raw line through two flops; reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], din};
    end
  end

  assign dout = sync_reg[1];

endmodule

// File: rtl/uart_batch_receiver.sv
// 8N1 UART receiver that packs BATCH_SIZE bytes into one wide word (first byte in the MS byte).
// Partial batches are dropped on an idle timeout or on a framing error.
module uart_batch_receiver
  import uart_batch_receiver_pkg::*;
#(
  parameter int DBITS         = DEFAULT_DBITS,
  parameter int SB_TICK       = DEFAULT_SB_TICK,
  parameter int BATCH_SIZE    = 4,
  parameter int TIMEOUT_TICKS = 480
) (
  input  logic                               clk_100MHz,
  input  logic                               reset,
  input  logic                               rx,
  input  logic                               sample_tick,
  output logic [DBITS*BATCH_SIZE-1:0]        batch_out,
  output logic                               batch_valid,
  output logic [$clog2(BATCH_SIZE+1)-1:0]    byte_count,
  output logic                               frame_err,
  output logic                               batch_timeout
);

  localparam int W      = DBITS * BATCH_SIZE;
  localparam int TICK_W = $clog2(SB_TICK);
  localparam int BIT_W  = $clog2(DBITS + 1);
  localparam int CNT_W  = $clog2(BATCH_SIZE + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_TICKS);

  localparam logic [TICK_W-1:0] TICK_MID   = TICK_W'(SB_TICK / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DBITS - 1);
  localparam logic [CNT_W-1:0]  BATCH_LAST = CNT_W'(BATCH_SIZE - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_TICKS - 1);

  logic rx_sync;

  rx_state_t         state_reg, state_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DBITS-1:0]  shreg_reg, shreg_next;
  logic [W-1:0]      pack_reg, pack_next;
  logic [CNT_W-1:0]  byte_count_reg, byte_count_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [W-1:0]      batch_out_reg, batch_out_next;
  logic              batch_valid_reg, batch_valid_next;
  logic              frame_err_reg, frame_err_next;
  logic              batch_timeout_reg, batch_timeout_next;
  logic [W-1:0]      pack_shifted;

  uart_batch_receiver_rx_sync u_rx_sync (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .din        (rx),
    .dout       (rx_sync)
  );

  // Pack register with the just-received byte appended at the LS end.
  assign pack_shifted = (pack_reg << DBITS) | W'(shreg_reg);

  // State and datapath registers; a reset abandons any frame and partial batch.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      tick_cnt_reg      <= '0;
      bit_cnt_reg       <= '0;
      shreg_reg         <= '0;
      pack_reg          <= '0;
      byte_count_reg    <= '0;
      idle_cnt_reg      <= '0;
      batch_out_reg     <= '0;
      batch_valid_reg   <= 1'b0;
      frame_err_reg     <= 1'b0;
      batch_timeout_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      tick_cnt_reg      <= tick_cnt_next;
      bit_cnt_reg       <= bit_cnt_next;
      shreg_reg         <= shreg_next;
      pack_reg          <= pack_next;
      byte_count_reg    <= byte_count_next;
      idle_cnt_reg      <= idle_cnt_next;
      batch_out_reg     <= batch_out_next;
      batch_valid_reg   <= batch_valid_next;
      frame_err_reg     <= frame_err_next;
      batch_timeout_reg <= batch_timeout_next;
    end
  end

  // Deframing FSM, packer and idle timeout; everything advances only on sample ticks.
  always_comb begin
    state_next         = state_reg;
    tick_cnt_next      = tick_cnt_reg;
    bit_cnt_next       = bit_cnt_reg;
    shreg_next         = shreg_reg;
    pack_next          = pack_reg;
    byte_count_next    = byte_count_reg;
    idle_cnt_next      = idle_cnt_reg;
    batch_out_next     = batch_out_reg;
    batch_valid_next   = 1'b0;
    frame_err_next     = 1'b0;
    batch_timeout_next = 1'b0;

    if (sample_tick) begin
      case (state_reg)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_next    = ST_START;
            tick_cnt_next = '0;
            idle_cnt_next = '0;
          end else if (byte_count_reg != '0) begin
            if (idle_cnt_reg == IDLE_LAST) begin
              byte_count_next    = '0;
              idle_cnt_next      = '0;
              batch_timeout_next = 1'b1;
            end else begin
              idle_cnt_next = idle_cnt_reg + 1'b1;
            end
          end
        end
        ST_START: begin
          if (tick_cnt_reg == TICK_MID) begin
            if (!rx_sync) begin
              state_next    = ST_DATA;
              tick_cnt_next = '0;
              bit_cnt_next  = '0;
            end else begin
              // Too short to be a start bit: treat as line noise.
              state_next = ST_IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            shreg_next    = (shreg_reg >> 1) | (DBITS'(rx_sync) << (DBITS - 1));
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BIT_LAST) begin
              state_next = ST_STOP;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            if (rx_sync) begin
              state_next = ST_IDLE;
              pack_next  = pack_shifted;
              if (byte_count_reg == BATCH_LAST) begin
                batch_out_next   = pack_shifted;
                batch_valid_next = 1'b1;
                byte_count_next  = '0;
              end else begin
                byte_count_next = byte_count_reg + 1'b1;
              end
            end else begin
              // Stop bit low: drop the partial batch and wait for the line to recover.
              frame_err_next  = 1'b1;
              byte_count_next = '0;
              state_next      = ST_BREAK;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_sync) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign batch_out     = batch_out_reg;
  assign batch_valid   = batch_valid_reg;
  assign byte_count    = byte_count_reg;
  assign frame_err     = frame_err_reg;
  assign batch_timeout = batch_timeout_reg;

endmodule

// File: tb/tb_uart_batch_receiver.sv
// Directed bench for uart_batch_receiver: tick every 4 clk, 16x oversampling, 4-byte batches.
module tb_uart_batch_receiver;

  localparam int BIT_CLKS = 64;  // 16 ticks * 4 clk per tick

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        sample_tick = 1'b0;
  logic [31:0] batch_out;
  logic        batch_valid;
  logic [2:0]  byte_count;
  logic        frame_err;
  logic        batch_timeout;

  int checks = 0;
  int passed = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int tmo_cnt = 0;
  logic [31:0] last_batch = '0;

  uart_batch_receiver #(
    .DBITS(8), .SB_TICK(16), .BATCH_SIZE(4), .TIMEOUT_TICKS(480)
  ) dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
    .rx            (rx),
    .sample_tick   (sample_tick),
    .batch_out     (batch_out),
    .batch_valid   (batch_valid),
    .byte_count    (byte_count),
    .frame_err     (frame_err),
    .batch_timeout (batch_timeout)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // One-clock sample tick every 4 clocks.
  initial begin
    logic [1:0] div;
    div = 2'd0;
    forever begin
      @(negedge clk_100MHz);
      div = div + 2'd1;
      sample_tick = (div == 2'd0);
    end
  end

  // Count output pulses (cycles high) and remember the last delivered batch.
  always @(negedge clk_100MHz) begin
    if (batch_valid) begin
      valid_cnt = valid_cnt + 1;
      last_batch = batch_out;
      $display("batch_valid batch_out=%08h", batch_out);
    end
    if (frame_err) begin
      ferr_cnt = ferr_cnt + 1;
      $display("frame_err pulse");
    end
    if (batch_timeout) begin
      tmo_cnt = tmo_cnt + 1;
      $display("batch_timeout pulse");
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    $display("send byte %02h stop=%0b", d, stop);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop;
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_clks(5);
    checks++; if (batch_out !== 32'h0) $display("FAIL reset_batch_out: got %h expected %h", batch_out, 32'h0); else passed++;
    checks++; if (batch_valid !== 1'b0) $display("FAIL reset_batch_valid: got %b expected 0", batch_valid); else passed++;
    checks++; if (byte_count !== 3'd0) $display("FAIL reset_byte_count: got %0d expected 0", byte_count); else passed++;
    checks++; if (frame_err !== 1'b0 || batch_timeout !== 1'b0) $display("FAIL reset_pulses: got %b%b expected 00", frame_err, batch_timeout); else passed++;
    reset = 1'b0;
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1);
    checks++; if (byte_count !== 3'd3) $display("FAIL b2b_partial_count: got %0d expected 3", byte_count); else passed++;
    send_frame(8'h78, 1'b1);
    wait_clks(10);
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL b2b_valid_count: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (last_batch !== 32'h12345678) $display("FAIL b2b_batch: got %h expected %h", last_batch, 32'h12345678); else passed++;
    checks++; if (byte_count !== 3'd0) $display("FAIL b2b_count_after: got %0d expected 0", byte_count); else passed++;
    checks++; if (batch_out !== 32'h12345678) $display("FAIL b2b_batch_hold: got %h expected %h", batch_out, 32'h12345678); else passed++;
  endtask

  task automatic test_timeout;
    int v0, t0;
    v0 = valid_cnt;
    t0 = tmo_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    checks++; if (byte_count !== 3'd2) $display("FAIL tmo_partial_count: got %0d expected 2", byte_count); else passed++;
    wait_clks(460 * 4);
    checks++; if (tmo_cnt - t0 !== 0) $display("FAIL tmo_early: got %0d expected 0", tmo_cnt - t0); else passed++;
    checks++; if (byte_count !== 3'd2) $display("FAIL tmo_count_held: got %0d expected 2", byte_count); else passed++;
    wait_clks(40 * 4);
    checks++; if (tmo_cnt - t0 !== 1) $display("FAIL tmo_pulse: got %0d expected 1", tmo_cnt - t0); else passed++;
    checks++; if (byte_count !== 3'd0) $display("FAIL tmo_count_cleared: got %0d expected 0", byte_count); else passed++;
    checks++; if (valid_cnt - v0 !== 0) $display("FAIL tmo_no_valid: got %0d expected 0", valid_cnt - v0); else passed++;
    checks++; if (batch_out !== 32'h12345678) $display("FAIL tmo_batch_unchanged: got %h expected %h", batch_out, 32'h12345678); else passed++;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    wait_clks(10);
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL tmo_next_valid: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (last_batch !== 32'h01020304) $display("FAIL tmo_next_batch: got %h expected %h", last_batch, 32'h01020304); else passed++;
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b0);
    rx = 1'b0;
    wait_clks(40 * BIT_CLKS);
    checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0); else passed++;
    checks++; if (valid_cnt - v0 !== 0) $display("FAIL ferr_no_valid: got %0d expected 0", valid_cnt - v0); else passed++;
    checks++; if (byte_count !== 3'd0) $display("FAIL ferr_count: got %0d expected 0", byte_count); else passed++;
    checks++; if (batch_out !== 32'h01020304) $display("FAIL ferr_batch_unchanged: got %h expected %h", batch_out, 32'h01020304); else passed++;
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    send_frame(8'h9A, 1'b1);
    send_frame(8'hBC, 1'b1);
    send_frame(8'hDE, 1'b1);
    send_frame(8'hF0, 1'b1);
    wait_clks(10);
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL ferr_recover_valid: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (last_batch !== 32'h9ABCDEF0) $display("FAIL ferr_recover_batch: got %h expected %h", last_batch, 32'h9ABCDEF0); else passed++;
    checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_single: got %0d expected 1", ferr_cnt - f0); else passed++;
  endtask

  task automatic test_glitch;
    int v0, f0, t0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    t0 = tmo_cnt;
    $display("glitch rx low 3 ticks");
    rx = 1'b0;
    wait_clks(12);
    rx = 1'b1;
    wait_clks(12 * BIT_CLKS);
    checks++; if (byte_count !== 3'd0) $display("FAIL glitch_count: got %0d expected 0", byte_count); else passed++;
    checks++; if ((valid_cnt - v0) + (ferr_cnt - f0) + (tmo_cnt - t0) !== 0) $display("FAIL glitch_pulses: got %0d expected 0", (valid_cnt - v0) + (ferr_cnt - f0) + (tmo_cnt - t0)); else passed++;
    checks++; if (batch_out !== 32'h9ABCDEF0) $display("FAIL glitch_batch: got %h expected %h", batch_out, 32'h9ABCDEF0); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    logic [7:0] b;
    send_frame(8'h55, 1'b1);
    checks++; if (byte_count !== 3'd1) $display("FAIL rst_pre_count: got %0d expected 1", byte_count); else passed++;
    b = 8'h66;
    $display("send partial byte %02h then reset", b);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
    reset = 1'b1;
    rx = 1'b1;
    wait_clks(1);
    reset = 1'b0;
    checks++; if (batch_out !== 32'h0) $display("FAIL rst_batch_out: got %h expected %h", batch_out, 32'h0); else passed++;
    checks++; if (byte_count !== 3'd0) $display("FAIL rst_byte_count: got %0d expected 0", byte_count); else passed++;
    checks++; if (batch_valid !== 1'b0) $display("FAIL rst_batch_valid: got %b expected 0", batch_valid); else passed++;
    wait_clks(3 * BIT_CLKS);
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b1);
    send_frame(8'h5A, 1'b1);
    send_frame(8'h0F, 1'b1);
    send_frame(8'hF0, 1'b1);
    wait_clks(10);
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL rst_next_valid: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (last_batch !== 32'hC35A0FF0) $display("FAIL rst_next_batch: got %h expected %h", last_batch, 32'hC35A0FF0); else passed++;
  endtask

  // Behavioural stand-in for the transmit path: tx_in sent MS byte first.
  task automatic test_loopback;
    int v0;
    logic [31:0] tx_in;
    tx_in = 32'hDEADBEEF;
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) begin
      send_frame(tx_in[31 - 8*i -: 8], 1'b1);
    end
    wait_clks(10);
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL loop_valid: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (batch_out !== 32'hDEADBEEF) $display("FAIL loop_batch: got %h expected %h", batch_out, 32'hDEADBEEF); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_timeout();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
